apb_sram_slave: RTL and testbench

- Parametrised APB slave wrapping an on-chip word-addressed SRAM array; target device of the APB SRAM testbench.
- Generalises the fixed single-configuration SRAM: configurable data width, depth and wait states, out-of-range error response, and optional APB4 byte strobes.
- Sits directly on the apb_inf bus signals, behind a single APB master.

---
 rtl/apb_sram_slave_if.sv | 30 +++
 rtl/apb_sram_slave.sv | 145 ++++++++++++++
 tb/tb_apb_sram_slave.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_sram_slave_if.sv
// APB bus bundle between a single master and apb_sram_slave.
// With APB_SRAM_PSTRB_EN defined the bundle also carries the pstrb byte strobes.
interface apb_sram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_SRAM_PSTRB_EN
   logic [DATA_WIDTH/8-1:0] pstrb;
`endif
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

`ifdef APB_SRAM_PSTRB_EN
   modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                   output prdata, pready, pslverr);
`else
   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
`endif
endinterface

// File: rtl/apb_sram_slave.sv
// APB slave over a word-addressed SRAM with configurable wait states and out-of-range error.
// Optional APB4 byte strobes are enabled with the macro APB_SRAM_PSTRB_EN.
module apb_sram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int SRAM_DEPTH  = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   apb_sram_slave_if.slave bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int MEM_AW = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
   localparam int CMP_W  = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t                state_r, state_s;
   logic [2:0]            cnt_r, cnt_s;
   logic                  write_r, write_s;
   logic [MEM_AW-1:0]     idx_r, idx_s;
   logic                  oor_r, oor_s;
   logic                  pready_r, pready_s;
   logic                  pslverr_r, pslverr_s;
   logic [DATA_WIDTH-1:0] prdata_r;
   logic                  rd_en_s;
   logic                  wr_en_s;
   logic [MEM_AW-1:0]     rd_idx_s;
   logic [ADDR_WIDTH-1:0] word_s;
   logic [MEM_AW-1:0]     word_idx_s;
   logic                  word_oor_s;
   logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

   // Range check uses the full word index so high address bits never alias into the array.
   assign word_s     = bus.paddr >> OFF_W;
   assign word_idx_s = word_s[MEM_AW-1:0];
   assign word_oor_s = CMP_W'(word_s) >= CMP_W'(SRAM_DEPTH);

   assign bus.prdata  = prdata_r;
   assign bus.pready  = pready_r;
   assign bus.pslverr = pslverr_r;

   // Next-state and next-output decode.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      write_s   = write_r;
      idx_s     = idx_r;
      oor_s     = oor_r;
      pready_s  = 1'b0;
      pslverr_s = 1'b0;
      rd_en_s   = 1'b0;
      wr_en_s   = 1'b0;
      rd_idx_s  = idx_r;
      case (state_r)
         IDLE: begin
            if (bus.psel && !bus.penable) begin
               state_s = ACCESS;
               write_s = bus.pwrite;
               idx_s   = word_idx_s;
               oor_s   = word_oor_s;
               cnt_s   = WAIT_LOAD;
               if (WAIT_LOAD == 3'd0) begin
                  pready_s  = 1'b1;
                  pslverr_s = word_oor_s;
                  rd_en_s   = !bus.pwrite && !word_oor_s;
                  rd_idx_s  = word_idx_s;
               end else begin
                  pready_s = 1'b0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (!bus.psel) begin
               state_s = IDLE;
               cnt_s   = 3'd0;
            end else if (pready_r) begin
               wr_en_s = write_r && !oor_r;
               state_s = IDLE;
               cnt_s   = 3'd0;
            end else if (cnt_r <= 3'd1) begin
               cnt_s     = 3'd0;
               pready_s  = 1'b1;
               pslverr_s = oor_r;
               rd_en_s   = !write_r && !oor_r;
            end else begin
               cnt_s = cnt_r - 3'd1;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 3'd0;
         end
      endcase
   end

   // State and registered bus outputs; reset leaves the array contents alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= 3'd0;
         write_r   <= 1'b0;
         idx_r     <= {MEM_AW{1'b0}};
         oor_r     <= 1'b0;
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
         prdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         write_r   <= write_s;
         idx_r     <= idx_s;
         oor_r     <= oor_s;
         pready_r  <= pready_s;
         pslverr_r <= pslverr_s;
         prdata_r  <= rd_en_s ? mem[rd_idx_s] : {DATA_WIDTH{1'b0}};
      end
   end

`ifdef APB_SRAM_PSTRB_EN
   // Commit only the strobed byte lanes at the completion edge.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.pstrb[b]) begin
               mem[idx_r][8*b +: 8] <= bus.pwdata[8*b +: 8];
            end
         end
      end
   end
`else
   // Commit the full word at the completion edge.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en_s) begin
         mem[idx_r] <= bus.pwdata;
      end
   end
`endif

endmodule

// File: tb/tb_apb_sram_slave.sv
// Randomised self-checking bench for apb_sram_slave: one instance with no wait states, one with three.
module tb_apb_sram_slave;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // Reference memory keyed by {instance, word index}; absent keys hold unknown data.
   logic [31:0] refm [longint];

   always #5 clk = ~clk;

   apb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 (), bus3 ();

   apb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .WAIT_STATES(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   apb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .WAIT_STATES(3))
      dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   function automatic longint mkey(input int which, input logic [31:0] addr);
      return (longint'(which) << 32) | longint'(addr >> 2);
   endfunction

   task automatic drive(input int which, input logic s, input logic e, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
      if (which == 0) begin
         bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = d;
`ifdef APB_SRAM_PSTRB_EN
         bus0.pstrb = st;
`endif
      end else begin
         bus3.psel = s; bus3.penable = e; bus3.pwrite = w; bus3.paddr = a; bus3.pwdata = d;
`ifdef APB_SRAM_PSTRB_EN
         bus3.pstrb = st;
`endif
      end
   endtask

   task automatic sample(input int which, output logic [31:0] rd, output logic rdy, output logic err);
      if (which == 0) begin
         rd = bus0.prdata; rdy = bus0.pready; err = bus0.pslverr;
      end else begin
         rd = bus3.prdata; rdy = bus3.pready; err = bus3.pslverr;
      end
   endtask

   // One APB transfer; expectations come from the reference memory and the address rules.
   task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input bit scramble);
      longint      k;
      bit          oor, chk, done;
      logic [31:0] exp_rd, rd, mask, old;
      logic        rdy, err;
      int          cyc, ws;
      ws     = (which == 0) ? 0 : 3;
      k      = mkey(which, addr);
      oor    = (addr >> 2) >= 32'(DEPTH);
      chk    = 1'b1;
      exp_rd = 32'h0;
      if (!wr && !oor) begin
         if (refm.exists(k)) exp_rd = refm[k];
         else chk = 1'b0;
      end
      @(negedge clk);
      sample(which, rd, rdy, err);
      total++;
      if (rdy !== 1'b0 || err !== 1'b0 || rd !== 32'h0) begin
         bad++;
         $display("FAIL setup_idle dut%0d addr=%h: pready=%b pslverr=%b prdata=%h, required all zero",
                  which, addr, rdy, err, rd);
      end
      drive(which, 1'b1, 1'b0, wr, addr, data, strb);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         sample(which, rd, rdy, err);
         if (rdy === 1'b1) begin
            done = 1'b1;
            total++;
            if (cyc != ws + 1) begin
               bad++;
               $display("FAIL latency dut%0d addr=%h strb=%h: access cycles=%0d, required %0d",
                        which, addr, strb, cyc, ws + 1);
            end
            total++;
            if (err !== oor) begin
               bad++;
               $display("FAIL pslverr dut%0d addr=%h: got %b, required %b", which, addr, err, oor);
            end
            if (chk) begin
               total++;
               if (rd !== exp_rd) begin
                  bad++;
                  $display("FAIL prdata dut%0d addr=%h wr=%b: got %h, required %h",
                           which, addr, wr, rd, exp_rd);
               end
            end
            drive(which, 1'b1, 1'b1, scramble ? ~wr : wr, scramble ? 32'($urandom) : addr, data, strb);
         end else begin
            total++;
            if (err !== 1'b0 || rd !== 32'h0) begin
               bad++;
               $display("FAIL wait_outputs dut%0d addr=%h cycle=%0d: pslverr=%b prdata=%h, required 0",
                        which, addr, cyc, err, rd);
            end
            drive(which, 1'b1, 1'b1, scramble ? ~wr : wr, scramble ? 32'($urandom) : addr,
                  scramble ? 32'($urandom) : data, strb);
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout dut%0d addr=%h: pready not seen in 20 cycles, required after %0d",
                  which, addr, ws + 1);
      end
      if (wr && !oor) begin
`ifdef APB_SRAM_PSTRB_EN
         for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
`else
         mask = 32'hFFFF_FFFF;
`endif
         if (refm.exists(k)) begin
            old     = refm[k];
            refm[k] = (old & ~mask) | (data & mask);
         end else if (mask == 32'hFFFF_FFFF) begin
            refm[k] = data;
         end else begin
            old = 32'h0;
         end
      end
   endtask

   task automatic idle(input int which, input int n);
      logic [31:0] rd;
      logic        rdy, err;
      repeat (n) begin
         @(negedge clk);
         sample(which, rd, rdy, err);
         total++;
         if (rdy !== 1'b0 || err !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL idle_outputs dut%0d: pready=%b pslverr=%b prdata=%h, required all zero",
                     which, rdy, err, rd);
         end
         drive(which, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
   endtask

   task automatic test_reset();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      drive(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
      @(negedge clk);
      total++;
      if (bus0.pready !== 1'b0 || bus0.pslverr !== 1'b0 || bus0.prdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_dut0: pready=%b pslverr=%b prdata=%h, required all zero",
                  bus0.pready, bus0.pslverr, bus0.prdata);
      end
      total++;
      if (bus3.pready !== 1'b0 || bus3.pslverr !== 1'b0 || bus3.prdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_dut3: pready=%b pslverr=%b prdata=%h, required all zero",
                  bus3.pready, bus3.pslverr, bus3.prdata);
      end
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst_n = 1'b1;
      idle(0, 2);
      idle(1, 2);
   endtask

   task automatic test_basic();
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
      xfer(1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0);
      xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
      idle(0, 1);
      idle(1, 1);
   endtask

   task automatic test_out_of_range();
      for (int w = 0; w < 2; w++) begin
         xfer(w, 1'b1, 32'h0, 32'h0BAD_F00D + 32'(w), 4'hF, 1'b0);
         xfer(w, 1'b1, 32'h1000, 32'hA5A5_A5A5, 4'hF, 1'b0);
         xfer(w, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
         xfer(w, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
         xfer(w, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 4'hF, 1'b0);
         xfer(w, 1'b1, 32'hFFC, 32'hC0DE_0FFC, 4'hF, 1'b0);
         xfer(w, 1'b0, 32'hFFF, 32'h0, 4'hF, 1'b0);
         xfer(w, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
         idle(w, 1);
      end
   endtask

   task automatic test_back_to_back();
      for (int w = 0; w < 2; w++) begin
         xfer(w, 1'b1, 32'h4, 32'h4444_0000 + 32'(w), 4'hF, 1'b0);
         xfer(w, 1'b1, 32'h8, 32'h8888_0000 + 32'(w), 4'hF, 1'b0);
         xfer(w, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
         xfer(w, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
         xfer(w, 1'b1, 32'h8, 32'h0808_0808, 4'hF, 1'b0);
         xfer(w, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
         idle(w, 1);
      end
   endtask

   task automatic test_reset_mid();
      xfer(1, 1'b1, 32'h20, 32'h0000_0020, 4'hF, 1'b0);
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'hFFFF_0020, 4'hF);
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hFFFF_0020, 4'hF);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (bus3.pready !== 1'b0 || bus3.pslverr !== 1'b0 || bus3.prdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: pready=%b pslverr=%b prdata=%h, required all zero",
                     bus3.pready, bus3.pslverr, bus3.prdata);
         end
         drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      rst_n = 1'b1;
      xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
      idle(1, 1);
   endtask

   task automatic test_protocol();
      // psel dropped during the access phase, on both instances
      for (int w = 0; w < 2; w++) begin
         xfer(w, 1'b1, 32'h24, 32'h0000_0024, 4'hF, 1'b0);
         @(negedge clk);
         drive(w, 1'b1, 1'b0, 1'b1, 32'h24, 32'hEEEE_0024, 4'hF);
         @(negedge clk);
         drive(w, 1'b0, 1'b0, 1'b1, 32'h24, 32'hEEEE_0024, 4'hF);
         idle(w, 6);
         xfer(w, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0);
      end
      // penable high in IDLE is not a setup
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, 4'hF);
      repeat (3) begin
         @(negedge clk);
         total++;
         if (bus0.pready !== 1'b0 || bus0.pslverr !== 1'b0) begin
            bad++;
            $display("FAIL penable_idle: pready=%b pslverr=%b, required 0", bus0.pready, bus0.pslverr);
         end
      end
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
      idle(0, 1);
   endtask

`ifdef APB_SRAM_PSTRB_EN
   task automatic test_strobe();
      xfer(0, 1'b1, 32'h30, 32'h1122_3344, 4'hF, 1'b0);
      xfer(0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101, 1'b0);
      xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      total++;
      if (refm[mkey(0, 32'h30)] !== 32'h11BB_33DD) begin
         bad++;
         $display("FAIL strobe_model: reference holds %h, required 11bb33dd", refm[mkey(0, 32'h30)]);
      end
      xfer(0, 1'b1, 32'h30, 32'h0000_0000, 4'h0, 1'b0);
      xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
      idle(0, 1);
   endtask
`endif

   task automatic test_random();
      logic [31:0] a;
      int          r;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            else if (r == 8) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            else             a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
`ifdef APB_SRAM_PSTRB_EN
            xfer(w, 1'($urandom_range(0, 1)), a, 32'($urandom), 4'($urandom_range(0, 15)), 1'b1);
`else
            xfer(w, 1'($urandom_range(0, 1)), a, 32'($urandom), 4'hF, 1'b1);
`endif
            if ($urandom_range(0, 3) == 0) idle(w, 1);
         end
         idle(w, 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      test_protocol();
`ifdef APB_SRAM_PSTRB_EN
      test_strobe();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
